branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Parameters
REQ-001 WIDTH, default 32, PC and target width in bits.
REQ-002 BTB_DEPTH, default 16, number of BTB entries; power of two, at least 2; IDX = log2(BTB_DEPTH).
REQ-003 CTR_BITS, default 2, width of each saturating direction counter; at least 1.

Interface
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 f_pc  in  WIDTH  fetch-stage PC (word address).
REQ-007 f_pred_taken  out  1  fetch prediction: redirect fetch to f_pred_target.
REQ-008 f_pred_target  out  WIDTH  predicted target; 0 when f_pred_taken=0.
REQ-009 x_valid  in  1  execute stage holds a valid instruction this cycle.
REQ-010 x_pc  in  WIDTH  execute-stage PC.
REQ-011 x_is_branch  in  1  conditional branch (bne/blt class).
REQ-012 x_is_jump  in  1  unconditional transfer (j, jal, jr, bex-taken class).
REQ-013 x_taken  in  1  resolved outcome; ignored unless x_is_branch or x_is_jump.
REQ-014 x_target  in  WIDTH  resolved target address.
REQ-015 x_pred_taken, x_pred_target  in  1, WIDTH  fetch prediction carried down the pipeline with the instruction.
REQ-016 redirect  out  1  mispredict; pipeline flushes younger stages and refetches from redirect_pc.
REQ-017 redirect_pc  out  WIDTH  correct next PC; 0 when redirect=0.
REQ-018 stat_branches, stat_mispredicts  out  32 each  performance counters.

Function
REQ-019 BTB entry fields: valid, tag = pc[WIDTH-1:IDX], target, ctr (CTR_BITS), jmp (1 bit); index = pc[IDX-1:0].
REQ-020 Fetch lookup is combinational: hit = valid and tag match at index of f_pc.
REQ-021 f_pred_taken = hit and (jmp or ctr MSB set).
REQ-022 Resolution is combinational in the same cycle: ctl = x_valid and (x_is_branch or x_is_jump); act_taken = ctl and x_taken.
REQ-023 redirect = x_valid and ((x_pred_taken != act_taken) or (act_taken and x_pred_target != x_target)).
REQ-024 redirect_pc = x_target when act_taken, else x_pc+1 (WIDTH-bit wrap-around).
REQ-025 BTB update is written at the next rising edge; a second lookup port on x_pc determines x_hit.
REQ-026 ctl and x_hit: ctr increments if act_taken, decrements otherwise, saturating at all-ones and at 0; target <= x_target when act_taken; jmp <= x_is_jump.
REQ-027 ctl, miss, act_taken: allocate (overwriting any prior occupant): valid=1, tag, target=x_target, jmp=x_is_jump, ctr = weakly taken (MSB=1, all other bits 0).
REQ-028 ctl, miss, not taken: no BTB change.
REQ-029 x_valid, not ctl, and x_pred_taken (alias): clear valid of the x_hit entry, if any; redirect to x_pc+1 per REQ-023/024.
REQ-030 When the fetch and execute lookups hit the same index in the same cycle, fetch sees the pre-update contents; there is no bypass.
REQ-031 stat_branches increments on every ctl cycle; stat_mispredicts increments on every redirect cycle; both saturate at 0xFFFFFFFF.
REQ-032 x_valid=0: no BTB update, no counter update, redirect=0.

Reset
REQ-033 While reset=1 at a rising edge: all valid, ctr and jmp bits clear to 0, and both stat counters clear to 0.
REQ-034 While reset=1 at a rising edge: any concurrent BTB or counter update is suppressed.
REQ-035 Prediction outputs remain combinational during reset; after reset, f_pred_taken=0 for every f_pc.
REQ-036 Reset asserted mid-operation discards all learned state in one cycle; no partial update survives.

Verification
REQ-037 After reset, f_pc=0x40 -> f_pred_taken=0 and f_pred_target=0; both stats read 0.
REQ-038 Branch at x_pc=0x10: x_is_branch=1, x_taken=1, x_target=0x30, x_pred_taken=0 -> redirect=1, redirect_pc=0x30. Next cycle, f_pc=0x10 -> f_pred_taken=1, f_pred_target=0x30. stat_mispredicts=1.
REQ-039 The same branch resolved not-taken once (ctr 2->1) -> redirect_pc=0x11. Then f_pc=0x10 -> f_pred_taken=0. Three taken resolutions -> ctr saturates at 3, with no further increment.
REQ-040 Jump at x_pc=0x20 (x_is_jump=1, target 0x5) allocated -> f_pc=0x20 -> f_pred_taken=1. Then x_pred_taken=1 with x_target=0x7 -> redirect_pc=0x7; the entry target becomes 0x7.
REQ-041 Alias: a non-control instruction at x_pc=0x10 with x_pred_taken=1 -> redirect=1, redirect_pc=0x11, and the entry is invalidated. f_pc=0x10 then predicts not-taken.
REQ-042 With a populated BTB, pulse reset for one cycle during a resolving branch -> no allocation occurs, all predictions are not-taken, and both stats read 0.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// ============================================================================
// Module      : branch_predict_unit_if
// Description : Fetch-lookup and execute-resolution bundle between the core
//               pipeline (master) and the branch predictor (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predict_unit_if #(
   parameter int WIDTH = 32
);
   // Fetch-stage lookup
   logic [WIDTH-1:0] f_pc;
   logic             f_pred_taken;
   logic [WIDTH-1:0] f_pred_target;

   // Execute-stage resolution
   logic             x_valid;
   logic [WIDTH-1:0] x_pc;
   logic             x_is_branch;
   logic             x_is_jump;
   logic             x_taken;
   logic [WIDTH-1:0] x_target;
   logic             x_pred_taken;
   logic [WIDTH-1:0] x_pred_target;

   // Recovery and statistics
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;
   logic [31:0]      stat_branches;
   logic [31:0]      stat_mispredicts;

   modport master (
      output f_pc, x_valid, x_pc, x_is_branch, x_is_jump, x_taken,
             x_target, x_pred_taken, x_pred_target,
      input  f_pred_taken, f_pred_target, redirect, redirect_pc,
             stat_branches, stat_mispredicts
   );

   modport slave (
      input  f_pc, x_valid, x_pc, x_is_branch, x_is_jump, x_taken,
             x_target, x_pred_taken, x_pred_target,
      output f_pred_taken, f_pred_target, redirect, redirect_pc,
             stat_branches, stat_mispredicts
   );
endinterface

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module      : branch_predict_unit
// Description : Direct-mapped BTB with per-entry saturating direction
//               counters. Combinational fetch prediction, same-cycle
//               mispredict detection at execute, BTB update on the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_unit #(
   parameter int WIDTH     = 32,
   parameter int BTB_DEPTH = 16,
   parameter int CTR_BITS  = 2
) (
   input  wire logic            i_clk,
   input  wire logic            i_rst,
   branch_predict_unit_if.slave bus
);
   localparam int IDX   = $clog2(BTB_DEPTH);
   localparam int TAG_W = WIDTH - IDX;

   localparam logic [CTR_BITS-1:0] c_CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] c_CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
   localparam logic [31:0]         c_STAT_MAX = 32'hFFFF_FFFF;

   // BTB storage; tag and target carry no reset since valid gates their use
   logic                r_valid  [BTB_DEPTH];
   logic [TAG_W-1:0]    r_tag    [BTB_DEPTH];
   logic [WIDTH-1:0]    r_target [BTB_DEPTH];
   logic [CTR_BITS-1:0] r_ctr    [BTB_DEPTH];
   logic                r_jmp    [BTB_DEPTH];

   logic [31:0]         r_stat_br;
   logic [31:0]         r_stat_mis;

   // Fetch lookup port
   logic [IDX-1:0]      w_f_idx;
   logic                w_f_hit;
   logic                w_f_taken;

   assign w_f_idx   = bus.f_pc[IDX-1:0];
   assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == bus.f_pc[WIDTH-1:IDX]);
   assign w_f_taken = w_f_hit && (r_jmp[w_f_idx] || r_ctr[w_f_idx][CTR_BITS-1]);

   assign bus.f_pred_taken  = w_f_taken;
   assign bus.f_pred_target = w_f_taken ? r_target[w_f_idx] : '0;

   // Execute lookup port and resolution
   logic [IDX-1:0]      w_x_idx;
   logic                w_x_hit;
   logic                w_ctl;
   logic                w_act_taken;
   logic                w_redirect;
   logic [WIDTH-1:0]    w_next_pc;
   logic [CTR_BITS-1:0] w_ctr_cur;
   logic [CTR_BITS-1:0] w_ctr_next;

   assign w_x_idx     = bus.x_pc[IDX-1:0];
   assign w_x_hit     = r_valid[w_x_idx] && (r_tag[w_x_idx] == bus.x_pc[WIDTH-1:IDX]);
   assign w_ctl       = bus.x_valid && (bus.x_is_branch || bus.x_is_jump);
   assign w_act_taken = w_ctl && bus.x_taken;
   assign w_redirect  = bus.x_valid &&
                        ((bus.x_pred_taken != w_act_taken) ||
                         (w_act_taken && (bus.x_pred_target != bus.x_target)));
   assign w_next_pc   = w_act_taken ? bus.x_target : (bus.x_pc + WIDTH'(1));
   assign w_ctr_cur   = r_ctr[w_x_idx];

   // Saturating step of the resolved entry's direction counter
   always_comb begin
      w_ctr_next = w_ctr_cur;
      if (w_act_taken) begin
         if (w_ctr_cur != c_CTR_MAX) w_ctr_next = w_ctr_cur + CTR_BITS'(1);
      end else begin
         if (w_ctr_cur != '0)        w_ctr_next = w_ctr_cur - CTR_BITS'(1);
      end
   end

   assign bus.redirect         = w_redirect;
   assign bus.redirect_pc      = w_redirect ? w_next_pc : '0;
   assign bus.stat_branches    = r_stat_br;
   assign bus.stat_mispredicts = r_stat_mis;

   // BTB train / allocate / alias-invalidate; reset wipes all learned state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= '0;
            r_jmp[i]   <= 1'b0;
         end
      end else if (bus.x_valid) begin
         if (w_ctl && w_x_hit) begin
            r_ctr[w_x_idx] <= w_ctr_next;
            r_jmp[w_x_idx] <= bus.x_is_jump;
            if (w_act_taken) r_target[w_x_idx] <= bus.x_target;
         end else if (w_ctl && w_act_taken) begin
            r_valid[w_x_idx]  <= 1'b1;
            r_tag[w_x_idx]    <= bus.x_pc[WIDTH-1:IDX];
            r_target[w_x_idx] <= bus.x_target;
            r_jmp[w_x_idx]    <= bus.x_is_jump;
            r_ctr[w_x_idx]    <= c_CTR_WEAK;
         end else if (!w_ctl && bus.x_pred_taken && w_x_hit) begin
            // Non-control instruction aliased onto a taken entry: evict it
            r_valid[w_x_idx] <= 1'b0;
         end
      end
   end

   // Saturating performance counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stat_br  <= '0;
         r_stat_mis <= '0;
      end else begin
         if (w_ctl && (r_stat_br != c_STAT_MAX))       r_stat_br  <= r_stat_br + 32'd1;
         if (w_redirect && (r_stat_mis != c_STAT_MAX)) r_stat_mis <= r_stat_mis + 32'd1;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Directed self-checking bench for branch_predict_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;

   branch_predict_unit_if #(.WIDTH(32)) bus ();

   branch_predict_unit #(
      .WIDTH     (32),
      .BTB_DEPTH (16),
      .CTR_BITS  (2)
   ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one execute-stage instruction
   task automatic setx(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
      bus.x_valid       = v;
      bus.x_pc          = pc;
      bus.x_is_branch   = br;
      bus.x_is_jump     = jmp;
      bus.x_taken       = tk;
      bus.x_target      = tgt;
      bus.x_pred_taken  = ptk;
      bus.x_pred_target = ptgt;
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      setx(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      bus.f_pc = 32'h40;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset_pred_taken",  {31'b0, bus.f_pred_taken}, 32'h0);
      chk("reset_pred_target", bus.f_pred_target,          32'h0);
      chk("reset_stat_br",     bus.stat_branches,          32'h0);
      chk("reset_stat_mis",    bus.stat_mispredicts,       32'h0);

      // First taken branch at 0x10 allocates; same-cycle fetch sees no bypass
      step();
      bus.f_pc = 32'h10;
      setx(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
      #1;
      chk("alloc_redirect",    {31'b0, bus.redirect},      32'h1);
      chk("alloc_redirect_pc", bus.redirect_pc,            32'h30);
      chk("no_bypass",         {31'b0, bus.f_pred_taken},  32'h0);
      step();
      idle();
      #1;
      chk("learned_taken",     {31'b0, bus.f_pred_taken},  32'h1);
      chk("learned_target",    bus.f_pred_target,          32'h30);
      chk("stat_mis_1",        bus.stat_mispredicts,       32'h1);

      // Not-taken once: counter 2 -> 1, fall-through redirect
      setx(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 32'h30);
      #1;
      chk("nt_redirect_pc",    bus.redirect_pc,            32'h11);
      step();
      idle();
      #1;
      chk("nt_pred",           {31'b0, bus.f_pred_taken},  32'h0);

      // Taken x3: 1->2 (mispredicted), 2->3 (correct), 3 stays 3
      setx(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
      step();
      setx(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h30, 1'b1, 32'h30);
      #1;
      chk("correct_no_redirect", {31'b0, bus.redirect},    32'h0);
      chk("correct_redirect_pc", bus.redirect_pc,          32'h0);
      step();
      setx(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h30, 1'b1, 32'h30);
      step();
      // One not-taken from saturated 3 -> 2 still predicts taken
      setx(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 32'h30);
      step();
      idle();
      #1;
      chk("sat_still_taken",   {31'b0, bus.f_pred_taken},  32'h1);
      setx(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 32'h30);
      step();
      idle();
      #1;
      chk("sat_then_nt",       {31'b0, bus.f_pred_taken},  32'h0);
      chk("stat_br_7",         bus.stat_branches,          32'd7);
      chk("stat_mis_5",        bus.stat_mispredicts,       32'd5);

      // Jump at 0x20 (same index as 0x10) allocates over the branch
      setx(1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h5, 1'b0, 32'h0);
      #1;
      chk("jmp_redirect_pc",   bus.redirect_pc,            32'h5);
      step();
      idle();
      bus.f_pc = 32'h20;
      #1;
      chk("jmp_pred_taken",    {31'b0, bus.f_pred_taken},  32'h1);
      chk("jmp_pred_target",   bus.f_pred_target,          32'h5);
      bus.f_pc = 32'h10;
      #1;
      chk("evicted_by_jmp",    {31'b0, bus.f_pred_taken},  32'h0);

      // Jump predicted to 0x5 actually goes to 0x7: target retrains
      setx(1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h7, 1'b1, 32'h5);
      #1;
      chk("jmp_tgt_redirect",    {31'b0, bus.redirect},    32'h1);
      chk("jmp_tgt_redirect_pc", bus.redirect_pc,          32'h7);
      step();
      idle();
      bus.f_pc = 32'h20;
      #1;
      chk("jmp_new_target",    bus.f_pred_target,          32'h7);

      // Re-allocate branch at 0x10, then alias a non-control instruction onto it
      setx(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
      step();
      setx(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h99, 1'b1, 32'h30);
      #1;
      chk("alias_redirect",    {31'b0, bus.redirect},      32'h1);
      chk("alias_redirect_pc", bus.redirect_pc,            32'h11);
      step();
      idle();
      bus.f_pc = 32'h10;
      #1;
      chk("alias_invalidated", {31'b0, bus.f_pred_taken},  32'h0);
      chk("alias_stat_br",     bus.stat_branches,          32'd10);
      chk("alias_stat_mis",    bus.stat_mispredicts,       32'd9);

      // Invalid execute slot: no redirect even with a taken prediction
      setx(1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 32'h30, 1'b1, 32'h44);
      #1;
      chk("invalid_no_redirect", {31'b0, bus.redirect},    32'h0);
      chk("invalid_redirect_pc", bus.redirect_pc,          32'h0);

      // Fall-through wraps at the top of the address space
      setx(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 32'h30);
      #1;
      chk("wrap_redirect",     {31'b0, bus.redirect},      32'h1);
      chk("wrap_redirect_pc",  bus.redirect_pc,            32'h0);
      step();

      // Populate index 3, then pulse reset during a resolving branch
      setx(1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h50, 1'b0, 32'h0);
      step();
      idle();
      bus.f_pc = 32'h33;
      #1;
      chk("pop_pred_taken",    {31'b0, bus.f_pred_taken},  32'h1);
      chk("pop_stat_br",       bus.stat_branches,          32'd12);
      chk("pop_stat_mis",      bus.stat_mispredicts,       32'd11);
      rst = 1'b1;
      setx(1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 32'h60, 1'b0, 32'h0);
      step();
      rst = 1'b0;
      idle();
      bus.f_pc = 32'h44;
      #1;
      chk("rst_no_alloc",      {31'b0, bus.f_pred_taken},  32'h0);
      bus.f_pc = 32'h33;
      #1;
      chk("rst_cleared",       {31'b0, bus.f_pred_taken},  32'h0);
      bus.f_pc = 32'h20;
      #1;
      chk("rst_cleared_jmp",   {31'b0, bus.f_pred_taken},  32'h0);
      chk("rst_stat_br",       bus.stat_branches,          32'h0);
      chk("rst_stat_mis",      bus.stat_mispredicts,       32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

`default_nettype wire
